// File: rtl/decode_stage_if.sv
// decode_stage_if: instruction handshake, write-back port and decoded result bundle.
interface decode_stage_if #(parameter int DATA_W = 32, parameter int ADDR_W = 5);
  logic in_valid;
  logic in_ready;
  logic [31:0] Instruction;
  logic [DATA_W-1:0] opcplus4;
  logic RegWrite;
  logic Jal;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] wb_pc4;
  logic flush;
  logic out_valid;
  logic out_ready;
  logic [DATA_W-1:0] read_data_1;
  logic [DATA_W-1:0] read_data_2;
  logic [DATA_W-1:0] Sign_extend;
  logic [31:0] out_instr;
  logic [DATA_W-1:0] out_pc4;
  modport master (
    output in_valid, Instruction, opcplus4, RegWrite, Jal, wb_addr, wb_data, wb_pc4, flush, out_ready,
    input in_ready, out_valid, read_data_1, read_data_2, Sign_extend, out_instr, out_pc4
  );
  modport slave (
    input in_valid, Instruction, opcplus4, RegWrite, Jal, wb_addr, wb_data, wb_pc4, flush, out_ready,
    output in_ready, out_valid, read_data_1, read_data_2, Sign_extend, out_instr, out_pc4
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: register file with write-back bypass, immediate extension and a one-entry output register.
module decode_stage #(
  parameter int DATA_W = 32,
  parameter int REG_NUM = 32,
  parameter int ADDR_W = $clog2(REG_NUM)
) (
  input logic clock,
  input logic reset,
  decode_stage_if.slave d
);
  logic [DATA_W-1:0] rf [REG_NUM];
  logic [ADDR_W-1:0] wb_idx, rs, rt, hrs, hrt;
  logic [DATA_W-1:0] wb_val, op1, op2, imm;
  logic [5:0] opc;
  logic wr, cap, stall, zext;
  always_comb begin
    wb_idx = d.Jal ? ADDR_W'(REG_NUM - 1) : d.wb_addr;
    wb_val = d.Jal ? d.wb_pc4 : d.wb_data;
    wr = d.RegWrite && wb_idx != '0;
    rs = d.Instruction[21 +: ADDR_W];
    rt = d.Instruction[16 +: ADDR_W];
    hrs = d.out_instr[21 +: ADDR_W];
    hrt = d.out_instr[16 +: ADDR_W];
    op1 = (wr && wb_idx == rs) ? wb_val : rf[rs];
    op2 = (wr && wb_idx == rt) ? wb_val : rf[rt];
    d.in_ready = !d.out_valid || d.out_ready;
    cap = d.in_valid && d.in_ready && !d.flush;
    stall = d.out_valid && !d.out_ready;
    opc = d.Instruction[31:26];
    zext = opc inside {6'h00, 6'h02, 6'h03, 6'h09, 6'h0B, 6'h0C, 6'h0D, 6'h0E};
    imm = opc == 6'h0F ? DATA_W'({d.Instruction[15:0], 16'h0000}) :
          zext ? DATA_W'(d.Instruction[15:0]) : DATA_W'($signed(d.Instruction[15:0]));
  end
  // register 0 is never written, so its reset value of zero is what it always reads
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_NUM; i++) rf[i] <= '0;
      d.out_valid <= 1'b0;
      d.read_data_1 <= '0;
      d.read_data_2 <= '0;
      d.Sign_extend <= '0;
      d.out_instr <= '0;
      d.out_pc4 <= '0;
    end else begin
      if (wr) rf[wb_idx] <= wb_val;
      d.out_valid <= !d.flush && (cap || stall);
      if (cap) begin
        d.read_data_1 <= op1;
        d.read_data_2 <= op2;
        d.Sign_extend <= imm;
        d.out_instr <= d.Instruction;
        d.out_pc4 <= d.opcplus4;
      end else if (stall) begin
        if (wr && wb_idx == hrs) d.read_data_1 <= wb_val;
        if (wr && wb_idx == hrt) d.read_data_2 <= wb_val;
      end
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scenarios plus randomized traffic against an array-based reference model.
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  decode_stage_if #(.DATA_W(32), .ADDR_W(5)) d ();
  decode_stage_if #(.DATA_W(64), .ADDR_W(5)) e ();
  decode_stage #(.DATA_W(32), .REG_NUM(32)) u32 (.clock(clk), .reset(rst), .d(d.slave));
  decode_stage #(.DATA_W(64), .REG_NUM(32)) u64 (.clock(clk), .reset(rst), .d(e.slave));
  int checks = 0;
  int errors = 0;
  logic [31:0] m_rf [32];
  logic m_v;
  logic [31:0] m_instr, m_pc4, m_op1, m_op2, m_imm;
  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] a, input logic [4:0] b, input logic [15:0] imm);
    return {op, a, b, imm};
  endfunction
  function automatic logic [31:0] exp_imm(input logic [31:0] ins);
    logic [31:0] z;
    z = {16'h0000, ins[15:0]};
    case (ins[31:26])
      6'h00, 6'h02, 6'h03, 6'h09, 6'h0B, 6'h0C, 6'h0D, 6'h0E: return z;
      6'h0F: return z << 16;
      default: return {{16{ins[15]}}, ins[15:0]};
    endcase
  endfunction
  task automatic model_reset;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    m_v = 1'b0;
    m_instr = 0; m_pc4 = 0; m_op1 = 0; m_op2 = 0; m_imm = 0;
  endtask
  // architectural view: writes land first, then operands are read from the updated file
  task automatic model_step;
    logic cap, stall;
    logic [4:0] idx;
    if (rst) return;
    cap = d.in_valid && (!m_v || d.out_ready) && !d.flush;
    stall = m_v && !d.out_ready;
    idx = d.Jal ? 5'd31 : d.wb_addr;
    if (d.RegWrite && idx != 0) m_rf[idx] = d.Jal ? d.wb_pc4 : d.wb_data;
    if (cap) begin
      m_instr = d.Instruction;
      m_pc4 = d.opcplus4;
      m_imm = exp_imm(d.Instruction);
    end
    if (cap || stall) begin
      m_op1 = m_rf[m_instr[25:21]];
      m_op2 = m_rf[m_instr[20:16]];
    end
    m_v = !d.flush && (cap || stall);
  endtask
  task automatic tick;
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic idle;
    d.in_valid = 0; d.Instruction = 0; d.opcplus4 = 0; d.RegWrite = 0; d.Jal = 0;
    d.wb_addr = 0; d.wb_data = 0; d.wb_pc4 = 0; d.flush = 0; d.out_ready = 1;
    e.in_valid = 0; e.Instruction = 0; e.opcplus4 = '0; e.RegWrite = 0; e.Jal = 0;
    e.wb_addr = 0; e.wb_data = '0; e.wb_pc4 = '0; e.flush = 0; e.out_ready = 1;
  endtask
  task automatic put(input logic [31:0] ins, input logic [31:0] pc);
    d.in_valid = 1; d.Instruction = ins; d.opcplus4 = pc;
  endtask
  task automatic wb(input logic en, input logic jal, input logic [4:0] a, input logic [31:0] v, input logic [31:0] pc);
    d.RegWrite = en; d.Jal = jal; d.wb_addr = a; d.wb_data = v; d.wb_pc4 = pc;
  endtask
  task automatic test_reset;
    idle();
    rst = 1; model_reset();
    #1;
    checks++; if (d.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", d.out_valid); end
    checks++; if (d.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", d.in_ready); end
    checks++; if ({d.read_data_1, d.read_data_2, d.Sign_extend, d.out_instr, d.out_pc4} !== 160'h0) begin
      errors++; $display("FAIL reset_data: got %h %h %h %h %h want all 0", d.read_data_1, d.read_data_2, d.Sign_extend, d.out_instr, d.out_pc4);
    end
    tick(); tick();
    rst = 0;
    tick();
  endtask
  task automatic test_basic;
    wb(1, 0, 5, 32'h1234, 0);
    tick();
    wb(0, 0, 0, 0, 0);
    put(mk(6'h00, 5, 0, {5'd3, 5'd0, 6'h21}), 32'h0040_0004);
    tick();
    d.in_valid = 0;
    checks++; if (d.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", d.out_valid); end
    checks++; if (d.read_data_1 !== 32'h1234) begin errors++; $display("FAIL basic_rd1: got %h want 00001234", d.read_data_1); end
    checks++; if (d.read_data_2 !== 32'h0) begin errors++; $display("FAIL basic_rd2: got %h want 0", d.read_data_2); end
    checks++; if (d.out_pc4 !== 32'h0040_0004) begin errors++; $display("FAIL basic_pc4: got %h want 00400004", d.out_pc4); end
    tick();
    checks++; if (d.out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %b want 0", d.out_valid); end
  endtask
  task automatic test_bypass;
    wb(1, 0, 7, 32'hDEAD_BEEF, 0);
    put(mk(6'h23, 7, 7, 16'h0004), 32'h8);
    tick();
    checks++; if (d.read_data_1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_rd1: got %h want deadbeef", d.read_data_1); end
    checks++; if (d.read_data_2 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_rd2: got %h want deadbeef", d.read_data_2); end
    wb(1, 0, 0, 32'hFFFF_FFFF, 0);
    put(mk(6'h23, 0, 0, 16'h0004), 32'hC);
    tick();
    wb(0, 0, 0, 0, 0);
    d.in_valid = 0;
    checks++; if ({d.read_data_1, d.read_data_2} !== 64'h0) begin errors++; $display("FAIL bypass_r0: got %h %h want 0 0", d.read_data_1, d.read_data_2); end
    tick();
  endtask
  task automatic test_jal;
    wb(1, 1, 5, 32'h0BAD, 32'h0040_0010);
    tick();
    wb(0, 0, 0, 0, 0);
    put(mk(6'h00, 31, 5, 16'h0), 32'h10);
    tick();
    d.in_valid = 0;
    checks++; if (d.read_data_1 !== 32'h0040_0010) begin errors++; $display("FAIL jal_r31: got %h want 00400010", d.read_data_1); end
    checks++; if (d.read_data_2 !== 32'h1234) begin errors++; $display("FAIL jal_wbaddr_ignored: got %h want 00001234", d.read_data_2); end
    tick();
  endtask
  task automatic test_stall;
    logic [31:0] x, y;
    x = mk(6'h00, 1, 9, {5'd2, 5'd0, 6'h21});
    y = mk(6'h0D, 2, 3, 16'h00FF);
    put(x, 32'h100);
    tick();
    d.out_ready = 0;
    put(y, 32'h104);
    for (int c = 1; c <= 3; c++) begin
      if (c == 2) wb(1, 0, 9, 32'h55, 0); else wb(0, 0, 0, 0, 0);
      #1;
      checks++; if (d.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready c%0d: got %b want 0", c, d.in_ready); end
      tick();
      checks++; if (d.out_valid !== 1'b1 || d.out_instr !== x || d.out_pc4 !== 32'h100) begin
        errors++; $display("FAIL stall_hold c%0d: got %b %h %h want 1 %h 00000100", c, d.out_valid, d.out_instr, d.out_pc4, x);
      end
      checks++; if (d.read_data_2 !== (c >= 2 ? 32'h55 : 32'h0)) begin
        errors++; $display("FAIL stall_rd2 c%0d: got %h want %h", c, d.read_data_2, c >= 2 ? 32'h55 : 32'h0);
      end
    end
    wb(0, 0, 0, 0, 0);
    d.out_ready = 1;
    #1;
    checks++; if (d.in_ready !== 1'b1) begin errors++; $display("FAIL stall_release: got %b want 1", d.in_ready); end
    tick();
    d.in_valid = 0;
    checks++; if (d.out_valid !== 1'b1 || d.out_instr !== y) begin errors++; $display("FAIL stall_next: got %b %h want 1 %h", d.out_valid, d.out_instr, y); end
    tick();
  endtask
  task automatic test_imm;
    logic [5:0] ops [5];
    logic [31:0] want [5];
    ops = '{6'h23, 6'h0C, 6'h0F, 6'h00, 6'h08};
    want = '{32'hFFFF_8001, 32'h0000_8001, 32'h8001_0000, 32'h0000_8001, 32'hFFFF_8001};
    for (int i = 0; i < 5; i++) begin
      put(mk(ops[i], 0, 0, 16'h8001), 0);
      tick();
      checks++; if (d.Sign_extend !== want[i]) begin errors++; $display("FAIL imm op%h: got %h want %h", ops[i], d.Sign_extend, want[i]); end
    end
    d.in_valid = 0;
    e.in_valid = 1; e.Instruction = mk(6'h23, 0, 0, 16'h8001);
    tick();
    e.in_valid = 0;
    checks++; if (e.Sign_extend !== 64'hFFFF_FFFF_FFFF_8001) begin errors++; $display("FAIL imm64_lw: got %h want ffffffffffff8001", e.Sign_extend); end
    e.in_valid = 1; e.Instruction = mk(6'h0F, 0, 0, 16'h8001);
    tick();
    e.in_valid = 0;
    checks++; if (e.Sign_extend !== 64'h0000_0000_8001_0000) begin errors++; $display("FAIL imm64_lui: got %h want 0000000080010000", e.Sign_extend); end
    tick();
  endtask
  task automatic test_flush;
    put(mk(6'h00, 4, 4, 16'h0), 32'h200);
    tick();
    d.out_ready = 0; d.flush = 1;
    put(mk(6'h00, 12, 12, 16'h0), 32'h204);
    wb(1, 0, 12, 32'hABC, 0);
    tick();
    wb(0, 0, 0, 0, 0);
    checks++; if (d.out_valid !== 1'b0) begin errors++; $display("FAIL flush_held: got %b want 0", d.out_valid); end
    d.out_ready = 1;
    tick();
    checks++; if (d.out_valid !== 1'b0) begin errors++; $display("FAIL flush_blocks_capture: got %b want 0", d.out_valid); end
    d.flush = 0;
    tick();
    d.in_valid = 0;
    checks++; if (d.out_valid !== 1'b1 || d.read_data_1 !== 32'hABC) begin errors++; $display("FAIL flush_wb_kept: got %b %h want 1 00000abc", d.out_valid, d.read_data_1); end
    tick();
  endtask
  task automatic test_reset_mid_stall;
    put(mk(6'h00, 7, 9, 16'h0), 32'h300);
    tick();
    d.in_valid = 0; d.out_ready = 0;
    tick();
    checks++; if (d.out_valid !== 1'b1) begin errors++; $display("FAIL rst_stall_setup: got %b want 1", d.out_valid); end
    #2;
    rst = 1; model_reset();
    wb(1, 0, 3, 32'h77, 0);
    #1;
    checks++; if (d.out_valid !== 1'b0 || e.out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b %b want 0 0", d.out_valid, e.out_valid); end
    checks++; if ({d.read_data_1, d.read_data_2, d.out_instr, d.out_pc4} !== 128'h0) begin
      errors++; $display("FAIL rst_async_data: got %h %h %h %h want all 0", d.read_data_1, d.read_data_2, d.out_instr, d.out_pc4);
    end
    tick();
    rst = 0;
    wb(0, 0, 0, 0, 0);
    #1;
    checks++; if (d.in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", d.in_ready); end
    d.out_ready = 1;
    for (int i = 0; i < 32; i++) begin
      put(mk(6'h00, 5'(i), 5'(i), 16'h0), 0);
      tick();
      checks++; if (d.out_valid !== 1'b1 || d.read_data_1 !== 32'h0 || d.read_data_2 !== 32'h0) begin
        errors++; $display("FAIL rst_reg%0d: got %b %h %h want 1 0 0", i, d.out_valid, d.read_data_1, d.read_data_2);
      end
    end
    d.in_valid = 0;
    tick();
  endtask
  task automatic test_random;
    logic [5:0] ops [13];
    logic [4:0] regs [6];
    ops = '{6'h00, 6'h02, 6'h03, 6'h09, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h08, 6'h2B, 6'h04};
    regs = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd31};
    for (int n = 0; n < 800; n++) begin
      if (m_v) begin
        checks++; if (d.out_valid !== 1'b1 || d.out_instr !== m_instr || d.out_pc4 !== m_pc4) begin
          errors++; $display("FAIL rand_hold n%0d: got %b %h %h want 1 %h %h", n, d.out_valid, d.out_instr, d.out_pc4, m_instr, m_pc4);
        end
        checks++; if (d.read_data_1 !== m_op1 || d.read_data_2 !== m_op2) begin
          errors++; $display("FAIL rand_ops n%0d: got %h %h want %h %h", n, d.read_data_1, d.read_data_2, m_op1, m_op2);
        end
        checks++; if (d.Sign_extend !== m_imm) begin errors++; $display("FAIL rand_imm n%0d: got %h want %h", n, d.Sign_extend, m_imm); end
      end else begin
        checks++; if (d.out_valid !== 1'b0) begin errors++; $display("FAIL rand_idle n%0d: got %b want 0", n, d.out_valid); end
      end
      d.in_valid = $urandom_range(0, 3) != 0;
      d.out_ready = $urandom_range(0, 2) != 0;
      d.flush = $urandom_range(0, 9) == 0;
      d.Instruction = {($urandom_range(0, 3) == 0) ? 6'($urandom) : ops[$urandom_range(0, 12)],
                       regs[$urandom_range(0, 5)], regs[$urandom_range(0, 5)], 16'($urandom)};
      d.opcplus4 = $urandom;
      wb($urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0, regs[$urandom_range(0, 5)], $urandom, $urandom);
      #1;
      checks++; if (d.in_ready !== (!m_v || d.out_ready)) begin errors++; $display("FAIL rand_in_ready n%0d: got %b want %b", n, d.in_ready, !m_v || d.out_ready); end
      tick();
    end
    idle();
  endtask
  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_jal();
    test_stall();
    test_imm();
    test_flush();
    test_reset_mid_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter DATA_W, default 32: register, operand and write-back width; legal values 32 or 64.
REQ-002 Parameter REG_NUM, default 32: number of architectural registers; power of two, 8..32.
REQ-003 Parameter ADDR_W, default $clog2(REG_NUM) (5): register index width.
REQ-004 clock  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  Instruction/opcplus4 valid this cycle.
REQ-007 in_ready  out  1  stage accepts a new instruction this cycle.
REQ-008 Instruction  in  32  instruction to decode.
REQ-009 opcplus4  in  DATA_W  PC+4 of the incoming instruction.
REQ-010 RegWrite  in  1  write-back enable.
REQ-011 Jal  in  1  write-back is a link write to register REG_NUM-1.
REQ-012 wb_addr  in  ADDR_W  write-back destination index.
REQ-013 wb_data  in  DATA_W  write-back data (non-link).
REQ-014 wb_pc4  in  DATA_W  link data for Jal write-back.
REQ-015 flush  in  1  discard the instruction held in the output register.
REQ-016 out_valid  out  1  output register holds a decoded instruction.
REQ-017 out_ready  in  1  downstream accepts the output this cycle.
REQ-018 read_data_1 / read_data_2  out  DATA_W  operands for rs = Instruction[25:21], rt = Instruction[20:16] (indices truncated to ADDR_W).
REQ-019 Sign_extend  out  DATA_W  extended immediate.
REQ-020 out_instr  out  32; out_pc4  out  DATA_W: registered copies of Instruction/opcplus4.

Function
REQ-021 Register file SHALL hold REG_NUM x DATA_W; register 0 SHALL always read 0, and writes to it are dropped.
REQ-022 Write-back: when RegWrite=1, destination = Jal ? REG_NUM-1 : wb_addr; data = Jal ? wb_pc4 : wb_data; written at the rising edge.
REQ-023 Read bypass: a same-cycle write to a nonzero index equal to rs or rt SHALL supply the write data to the captured operand.
REQ-024 in_ready = !out_valid || out_ready (combinational).
REQ-025 Capture (in_valid && in_ready && !flush): output register SHALL load operands, immediate, Instruction and opcplus4; out_valid <= 1; latency one cycle.
REQ-026 in_ready && !(in_valid && !flush) SHALL set out_valid <= 0.
REQ-027 Stall (out_valid && !out_ready): outputs held stable, except a write-back to a nonzero index matching the held rs/rt SHALL update read_data_1/read_data_2 next cycle.
REQ-028 flush=1 SHALL set out_valid <= 0 next cycle and block capture that cycle; the write-back still executes.
REQ-029 Immediate, from opcode = Instruction[31:26]: 000000/000010/000011 -> zero-extend imm16; 001111 -> imm16 << 16, zero-filled to DATA_W; 001001/001011/001100/001101/001110 -> zero-extend; all others -> sign-extend from bit 15 to DATA_W.
REQ-030 out_* data fields are don't-care while out_valid=0 but SHALL hold their last value (no X).

Reset
REQ-031 reset=1 SHALL immediately, without a clock edge, clear all registers to 0, out_valid to 0, and all out_* data to 0.
REQ-032 reset mid-stall SHALL discard the held instruction; in_ready=1 is the first cycle after release.
REQ-033 Write-back with reset asserted SHALL be ignored.

Verification
REQ-034 Write r5=0x1234 via wb; issue addu rd,r5,r0 -> next cycle out_valid=1, read_data_1=0x1234, read_data_2=0.
REQ-035 Same-cycle wb r7=0xDEADBEEF and capture of instr with rs=7 -> read_data_1=0xDEADBEEF; wb to r0 -> reads 0.
REQ-036 Jal wb with wb_pc4=0x00400010 -> register 31 (REG_NUM-1) reads 0x00400010; wb_addr ignored.
REQ-037 out_ready=0 for 3 cycles with held rt=9, wb r9=0x55 in cycle 2 -> outputs stable, in_ready=0, read_data_2 becomes 0x55; next instr accepted when out_ready=1.
REQ-038 Immediates, imm16=0x8001: opcode 100011 -> 0xFFFF8001; 001100 -> 0x00008001; 001111 -> 0x80010000; DATA_W=64 lw -> 0xFFFFFFFFFFFF8001.
REQ-039 Assert reset asynchronously mid-stall and pulse flush with in_valid=1 -> out_valid=0 immediately / next cycle respectively, all registers read 0 after reset.
